rst_sequencer: RTL and testbench
================================

# rst_sequencer

Parametrised board reset sequencer for the demo system FPGA tops. It generates a power-on reset hold and debounces the active-low board reset button. It also accepts a software reset request and releases `NumDomains` active-low reset outputs in a staggered order (domain 0 first). A reset-cause register and a saturating sequence counter are exposed for software. The block replaces hand-written power-on counters in top levels and sits between the clock generator and the system reset consumers.

## Interface
- `NumDomains`, 3: number of staged reset outputs, 1..8.
- `PorDelay`, 5: cycles after `rst_sys_i` deassertion before the hold begins, 0..65535.
- `HoldCycles`, 195: minimum cycles all outputs are held asserted, 1..65535.
- `StageGap`, 16: cycles between successive domain releases, 0..65535.
- `DebounceCycles`, 1000: consecutive stable synchronised samples required to accept a button level change, 1..65535.
- `clk_sys_i  in  1`: system clock; the only clock.
- `rst_sys_i  in  1`: asynchronous, active-high reset.
- `nrst_btn_i  in  1`: raw board button, active-low, asynchronous to `clk_sys_i`.
- `sw_rst_req_i  in  1`: software reset request, sampled each cycle, synchronous.
- `rst_n_o  out  NumDomains`: staged active-low resets, registered.
- `seq_busy_o  out  1`: high while any `rst_n_o` bit is low.
- `rst_cause_o  out  3`: bit0 POR, bit1 button, bit2 software.
- `rst_count_o  out  8`: saturating count of non-POR reset sequences.

## Operation
- Button path: 2-flop synchroniser (reset value 1) feeds a debounce counter. The filtered level `btn_f` (reset value 1) flips only after the synchronised value differs from `btn_f` for `DebounceCycles` consecutive cycles. Any matching sample clears the counter.
- FSM states:
  - POR_WAIT (entered on reset): held `PorDelay` cycles, then goes to ASSERT. If `PorDelay`=0 it goes straight to ASSERT.
  - ASSERT: all `rst_n_o` low. The counter loads `HoldCycles` and reloads every cycle while `btn_f`=0. On reaching the end, `rst_n_o[0]` goes high and the FSM goes to RELEASE, or to RUN if `NumDomains`=1.
  - RELEASE: `rst_n_o[k]` goes high `StageGap` cycles after `rst_n_o[k-1]`. After the last domain is released the FSM goes to RUN. If `StageGap`=0, all domains rise together with domain 0.
  - RUN: all outputs high.
- Triggers:
  - A `btn_f` falling edge in RELEASE or RUN → ASSERT.
  - `sw_rst_req_i`=1 in RUN → ASSERT.
  - `sw_rst_req_i` is ignored in POR_WAIT, ASSERT and RELEASE.
  - `btn_f` edges in POR_WAIT are ignored, but `btn_f`=0 still extends the ASSERT hold.
- Cause register:
  - Reset value 3'b001.
  - On each trigger it is overwritten with {sw, btn, 0}.
  - Button and software in the same cycle gives 3'b110.
  - Holds its value until the next trigger.
- Counter: `rst_count_o` increments by 1 on each trigger, saturates at 255, and clears only on `rst_sys_i`.
- `seq_busy_o` equals NOT(AND of `rst_n_o`) and is registered alongside `rst_n_o`.

## Timing
- Reset values: `rst_n_o`=0, `seq_busy_o`=1, `rst_cause_o`=3'b001, `rst_count_o`=0, FSM=POR_WAIT, `btn_f`=1.
- Edge 1 is the first `clk_sys_i` rising edge with `rst_sys_i` low.
  - `rst_n_o[0]` rises at edge `PorDelay`+`HoldCycles`+1.
  - `rst_n_o[k]` rises at that edge + k·`StageGap`.
  - `seq_busy_o` falls on the same edge as the last release.
- Button press: the pin goes low and stays low from edge P.
  - Synchronised low is visible at P+2.
  - `btn_f` falls at P+2+`DebounceCycles`.
  - All `rst_n_o` and `seq_busy_o` are asserted at the following edge.
  - Cause and count update on that same edge.
- Button release: the hold of `HoldCycles` counts from the edge after `btn_f` rises.
- Software request: `sw_rst_req_i` sampled high at edge S in RUN → all `rst_n_o` low at S+1.
- Re-trigger during RELEASE: all already-released domains are re-asserted at the next edge and the full hold restarts.
- `rst_sys_i` asserted mid-sequence: all outputs return to reset values immediately (asynchronously), with no glitch-high on any `rst_n_o`.
- Debounce glitches shorter than `DebounceCycles` produce no `btn_f` change and no trigger.

## Test plan
Bench parameters: `NumDomains`=3, `PorDelay`=5, `HoldCycles`=195, `StageGap`=16, `DebounceCycles`=8.
- Power-on: deassert `rst_sys_i`, button high → `rst_n_o` steps 3'b001 at edge 201, 3'b011 at 217, 3'b111 at 233. `seq_busy_o` falls at 233. Cause 3'b001, count 0.
- Software reset in RUN: pulse `sw_rst_req_i` one cycle → `rst_n_o`=0 next edge. Cause 3'b100, count 1. Re-release 196 edges later, staged 16 apart.
- Button bounce: 5-cycle low glitches repeated 10 times → no trigger, `rst_n_o` stays 3'b111. Then hold the button low 300 cycles → asserted 11 edges after the stable low. The hold extends until release + 196 edges. Cause 3'b010.
- Simultaneous triggers: `btn_f` fall and `sw_rst_req_i` in the same RUN cycle → cause 3'b110, count increments by exactly 1.
- Mid-release events: a button press after `rst_n_o`=3'b001 → 3'b000 next edge, full sequence restarts. `rst_sys_i` asserted in RELEASE → immediate reset values, count cleared.
- Saturation: 260 software triggers → `rst_count_o` reads 255 and stays at 255.

Source files
------------

// File: rtl/rst_sequencer.sv
// rst_sequencer: board reset sequencer.
//   Holds all reset domains asserted for a power-on delay plus a minimum hold,
//   then releases them one at a time (domain 0 first), StageGap cycles apart.
//   A debounced active-low board button or a software request re-runs the
//   sequence. Software can read the cause of the last reset and a saturating
//   count of non-power-on sequences.
//
// Ports:
//   clk_sys_i     system clock (only clock)
//   rst_sys_i     asynchronous active-high reset
//   nrst_btn_i    raw active-low board button, asynchronous to clk_sys_i
//   sw_rst_req_i  synchronous software reset request
//   rst_n_o       staged active-low domain resets, registered
//   seq_busy_o    high while any rst_n_o bit is low, registered
//   rst_cause_o   last reset cause: bit0 POR, bit1 button, bit2 software
//   rst_count_o   saturating count of button/software reset sequences
module rst_sequencer #(
   parameter int unsigned NumDomains     = 3,
   parameter int unsigned PorDelay       = 5,
   parameter int unsigned HoldCycles     = 195,
   parameter int unsigned StageGap       = 16,
   parameter int unsigned DebounceCycles = 1000
) (
   input  logic                  clk_sys_i,
   input  logic                  rst_sys_i,
   input  logic                  nrst_btn_i,
   input  logic                  sw_rst_req_i,
   output logic [NumDomains-1:0] rst_n_o,
   output logic                  seq_busy_o,
   output logic [2:0]            rst_cause_o,
   output logic [7:0]            rst_count_o
);

   localparam logic [1:0] StPorWait = 2'd0;
   localparam logic [1:0] StAssert  = 2'd1;
   localparam logic [1:0] StRelease = 2'd2;
   localparam logic [1:0] StRun     = 2'd3;

   localparam logic [15:0] PorLast  = (PorDelay == 0) ? 16'd0 : 16'(PorDelay - 1);
   localparam logic [15:0] HoldLoad = 16'(HoldCycles);
   localparam logic [15:0] HoldLast = 16'(HoldCycles - 1);
   localparam logic [15:0] GapLast  = (StageGap == 0) ? 16'd0 : 16'(StageGap - 1);
   localparam logic [15:0] DebLast  = 16'(DebounceCycles - 1);

   // Button synchroniser and debounce filter
   logic [1:0]  btn_sync_q;
   logic        btn_f_q, btn_f_d;
   logic        btn_f_dly_q;
   logic [15:0] deb_cnt_q, deb_cnt_d;

   // Sequencer
   logic                  sw_req_q;
   logic [1:0]            state_q, state_d;
   logic [15:0]           cnt_q, cnt_d;
   logic [NumDomains-1:0] rst_n_q, rst_n_d;
   logic                  busy_q, busy_d;
   logic [2:0]            cause_q, cause_d;
   logic [7:0]            count_q, count_d;

   logic btn_fall, btn_trig, sw_trig;

   always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
      if (rst_sys_i) begin
         btn_sync_q  <= 2'b11;
         btn_f_q     <= 1'b1;
         btn_f_dly_q <= 1'b1;
         deb_cnt_q   <= '0;
      end else begin
         btn_sync_q  <= {btn_sync_q[0], nrst_btn_i};
         btn_f_q     <= btn_f_d;
         btn_f_dly_q <= btn_f_q;
         deb_cnt_q   <= deb_cnt_d;
      end
   end

   // Count consecutive samples that disagree with the filtered level; any
   // agreeing sample restarts the count.
   always_comb begin
      btn_f_d   = btn_f_q;
      deb_cnt_d = '0;
      if (btn_sync_q[1] != btn_f_q) begin
         if (deb_cnt_q == DebLast) begin
            btn_f_d   = btn_sync_q[1];
            deb_cnt_d = '0;
         end else begin
            deb_cnt_d = deb_cnt_q + 16'd1;
         end
      end
   end

   // Both triggers act one edge after they are observed: the button on the
   // registered falling edge of btn_f, software on its registered request.
   assign btn_fall = btn_f_dly_q & ~btn_f_q;
   assign btn_trig = btn_fall & ((state_q == StRelease) || (state_q == StRun));
   assign sw_trig  = sw_req_q & (state_q == StRun);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rst_n_d = rst_n_q;
      cause_d = cause_q;
      count_d = count_q;

      case (state_q)
         StPorWait: begin
            if (PorDelay == 0) begin
               // No delay phase: this edge already counts as the first hold cycle.
               state_d = StAssert;
               cnt_d   = HoldLast;
            end else if (cnt_q == PorLast) begin
               state_d = StAssert;
               cnt_d   = HoldLoad;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StAssert: begin
            rst_n_d = '0;
            if (!btn_f_q) begin
               cnt_d = HoldLoad;
            end else if (cnt_q == 16'd0) begin
               if ((StageGap == 0) || (NumDomains == 1)) begin
                  rst_n_d = '1;
                  state_d = StRun;
               end else begin
                  rst_n_d[0] = 1'b1;
                  state_d    = StRelease;
                  cnt_d      = GapLast;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         StRelease: begin
            if (cnt_q == 16'd0) begin
               // Released domains form a thermometer code from bit 0 upward.
               rst_n_d = rst_n_q | (rst_n_q << 1);
               if (&rst_n_d) begin
                  state_d = StRun;
               end else begin
                  cnt_d = GapLast;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         StRun: begin
            rst_n_d = '1;
         end
         default: begin
            state_d = StPorWait;
            cnt_d   = '0;
            rst_n_d = '0;
         end
      endcase

      if (btn_trig || sw_trig) begin
         state_d = StAssert;
         rst_n_d = '0;
         cnt_d   = HoldLoad;
         cause_d = {sw_trig, btn_trig, 1'b0};
         if (count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
         end
      end

      busy_d = ~&rst_n_d;
   end

   always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
      if (rst_sys_i) begin
         sw_req_q <= 1'b0;
         state_q  <= StPorWait;
         cnt_q    <= '0;
         rst_n_q  <= '0;
         busy_q   <= 1'b1;
         cause_q  <= 3'b001;
         count_q  <= '0;
      end else begin
         sw_req_q <= sw_rst_req_i;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rst_n_q  <= rst_n_d;
         busy_q   <= busy_d;
         cause_q  <= cause_d;
         count_q  <= count_d;
      end
   end

   assign rst_n_o     = rst_n_q;
   assign seq_busy_o  = busy_q;
   assign rst_cause_o = cause_q;
   assign rst_count_o = count_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: scoreboard bench for rst_sequencer.
//   Stimulus pushes each expected output change (edge number and full output
//   snapshot) into a queue; the monitor pops an entry whenever the outputs
//   change and compares both the edge and the values.
module tb_rst_sequencer;

   logic       clk;
   logic       rst_sys;
   logic       nrst_btn;
   logic       sw_rst_req;
   logic [2:0] rst_n_o;
   logic       seq_busy_o;
   logic [2:0] rst_cause_o;
   logic [7:0] rst_count_o;

   rst_sequencer #(
      .NumDomains    (3),
      .PorDelay      (5),
      .HoldCycles    (195),
      .StageGap      (16),
      .DebounceCycles(8)
   ) dut (
      .clk_sys_i   (clk),
      .rst_sys_i   (rst_sys),
      .nrst_btn_i  (nrst_btn),
      .sw_rst_req_i(sw_rst_req),
      .rst_n_o     (rst_n_o),
      .seq_busy_o  (seq_busy_o),
      .rst_cause_o (rst_cause_o),
      .rst_count_o (rst_count_o)
   );

   typedef struct packed {
      logic [31:0] cyc;
      logic [14:0] val;
   } exp_t;

   localparam logic [14:0] RstSnap = {3'b000, 1'b1, 3'b001, 8'h00};

   exp_t        exp_q[$];
   int          checks   = 0;
   int          failures = 0;
   int          edge_n;
   logic [14:0] prev_val;
   logic [14:0] cur_val;
   exp_t        mon_e;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
      $fatal(1, "watchdog");
   end

   // Edge 1 is the first rising edge with rst_sys low.
   always @(posedge clk or posedge rst_sys) begin
      if (rst_sys) edge_n <= 0;
      else         edge_n <= edge_n + 1;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, want, edge_n);
      end
   endtask

   task automatic push(input int cyc, input logic [2:0] rn, input logic [2:0] cause,
                       input logic [7:0] cnt);
      exp_t e;
      e.cyc = cyc;
      e.val = {rn, ~&rn, cause, cnt};
      exp_q.push_back(e);
   endtask

   // Returns just after edge n (inputs driven here are first sampled at n+1).
   task automatic wait_edge(input int n);
      while (edge_n < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      cur_val = {rst_n_o, seq_busy_o, rst_cause_o, rst_count_o};
      if (rst_sys) begin
         prev_val = RstSnap;
      end else if (cur_val !== prev_val) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_change: got %0h previous %0h (edge %0d)",
                     cur_val, prev_val, edge_n);
         end else begin
            mon_e = exp_q.pop_front();
            chk("ev_cycle", edge_n, mon_e.cyc);
            chk("ev_value", {17'd0, cur_val}, {17'd0, mon_e.val});
         end
         prev_val = cur_val;
      end
   end

   initial begin
      int e;
      int c;
      rst_sys    = 1'b0;
      nrst_btn   = 1'b1;
      sw_rst_req = 1'b0;
      #2 rst_sys = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_rst_n", {29'd0, rst_n_o}, 32'd0);
      chk("reset_busy", {31'd0, seq_busy_o}, 32'd1);
      chk("reset_cause", {29'd0, rst_cause_o}, 32'd1);
      chk("reset_count", {24'd0, rst_count_o}, 32'd0);

      // Power-on release: edges 201, 217, 233
      push(201, 3'b001, 3'b001, 8'd0);
      push(217, 3'b011, 3'b001, 8'd0);
      push(233, 3'b111, 3'b001, 8'd0);
      rst_sys = 1'b0;
      wait_edge(240);

      // Software reset in RUN; further requests in ASSERT and RELEASE ignored
      e = edge_n;
      push(e + 2,   3'b000, 3'b100, 8'd1);
      push(e + 198, 3'b001, 3'b100, 8'd1);
      push(e + 214, 3'b011, 3'b100, 8'd1);
      push(e + 230, 3'b111, 3'b100, 8'd1);
      sw_rst_req = 1'b1;
      wait_edge(e + 1);
      sw_rst_req = 1'b0;
      wait_edge(e + 50);
      sw_rst_req = 1'b1;
      wait_edge(e + 51);
      sw_rst_req = 1'b0;
      wait_edge(e + 200);
      sw_rst_req = 1'b1;
      wait_edge(e + 201);
      sw_rst_req = 1'b0;
      wait_edge(e + 235);

      // Bounce: ten 5-cycle low glitches must not trigger
      for (int i = 0; i < 10; i++) begin
         e = edge_n;
         nrst_btn = 1'b0;
         wait_edge(e + 5);
         nrst_btn = 1'b1;
         wait_edge(e + 10);
      end

      // Stable press for 300 cycles; hold runs 196 edges past btn_f rising
      e = edge_n;
      push(e + 11,  3'b000, 3'b010, 8'd2);
      push(e + 506, 3'b001, 3'b010, 8'd2);
      push(e + 522, 3'b011, 3'b010, 8'd2);
      push(e + 538, 3'b111, 3'b010, 8'd2);
      nrst_btn = 1'b0;
      wait_edge(e + 300);
      nrst_btn = 1'b1;
      wait_edge(e + 545);

      // Button and software triggers in the same RUN cycle
      e = edge_n;
      push(e + 11,  3'b000, 3'b110, 8'd3);
      push(e + 226, 3'b001, 3'b110, 8'd3);
      push(e + 242, 3'b011, 3'b110, 8'd3);
      push(e + 258, 3'b111, 3'b110, 8'd3);
      nrst_btn = 1'b0;
      wait_edge(e + 9);
      sw_rst_req = 1'b1;
      wait_edge(e + 10);
      sw_rst_req = 1'b0;
      wait_edge(e + 20);
      nrst_btn = 1'b1;
      wait_edge(e + 265);

      // Button press while only domain 0 is released
      e = edge_n;
      push(e + 2,   3'b000, 3'b100, 8'd4);
      push(e + 198, 3'b001, 3'b100, 8'd4);
      sw_rst_req = 1'b1;
      wait_edge(e + 1);
      sw_rst_req = 1'b0;
      wait_edge(e + 198);
      push(e + 209, 3'b000, 3'b010, 8'd5);
      push(e + 424, 3'b001, 3'b010, 8'd5);
      push(e + 440, 3'b011, 3'b010, 8'd5);
      push(e + 456, 3'b111, 3'b010, 8'd5);
      nrst_btn = 1'b0;
      wait_edge(e + 218);
      nrst_btn = 1'b1;
      wait_edge(e + 460);

      // System reset asserted during RELEASE
      e = edge_n;
      push(e + 2,   3'b000, 3'b100, 8'd6);
      push(e + 198, 3'b001, 3'b100, 8'd6);
      sw_rst_req = 1'b1;
      wait_edge(e + 1);
      sw_rst_req = 1'b0;
      wait_edge(e + 200);
      #3 rst_sys = 1'b1;
      #1;
      chk("async_rst_n", {29'd0, rst_n_o}, 32'd0);
      chk("async_busy", {31'd0, seq_busy_o}, 32'd1);
      chk("async_cause", {29'd0, rst_cause_o}, 32'd1);
      chk("async_count", {24'd0, rst_count_o}, 32'd0);
      chk("async_pending", exp_q.size(), 32'd0);
      repeat (3) @(negedge clk);
      push(201, 3'b001, 3'b001, 8'd0);
      push(217, 3'b011, 3'b001, 8'd0);
      push(233, 3'b111, 3'b001, 8'd0);
      rst_sys = 1'b0;
      wait_edge(240);

      // 260 software triggers: count saturates at 255
      for (int i = 1; i <= 260; i++) begin
         e = edge_n;
         c = (i > 255) ? 255 : i;
         push(e + 2,   3'b000, 3'b100, 8'(c));
         push(e + 198, 3'b001, 3'b100, 8'(c));
         push(e + 214, 3'b011, 3'b100, 8'(c));
         push(e + 230, 3'b111, 3'b100, 8'(c));
         sw_rst_req = 1'b1;
         wait_edge(e + 1);
         sw_rst_req = 1'b0;
         wait_edge(e + 232);
      end

      for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      chk("drain_pending", exp_q.size(), 32'd0);
      chk("count_saturated", {24'd0, rst_count_o}, 32'd255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
